// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler feeding one UART transmitter, 4 requesters
// Each requester carries its own baud select; the shared generator is re-pointed and allowed to settle between frames.
module uart_tx_sched #(
  parameter int OVS    = 16,
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  input  logic [7:0]  baud_cfg,
  input  logic        baud_tick,
  output logic [1:0]  baud_sel,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [3:0] TICK_LAST   = 4'(OVS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [3:0] tcnt, tcnt_n;
  logic [2:0] bidx, bidx_n;
  logic [7:0] scnt, scnt_n;
  logic [1:0] rr, rr_n;
  logic [1:0] owner_n, baud_sel_n;
  logic [3:0] grant_n;
  logic       tx_n, busy_n, done_n;

  logic       found;
  logic [1:0] pick, cand;
  logic [7:0] pick_data;
  logic [1:0] pick_cfg;
  logic       tick_end;
  logic [2:0] bidx_inc;

  // First pending requester at or after the rotating pointer wins.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    cand  = rr;
    for (int k = 0; k < 4; k++) begin
      cand = rr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_data = data_in[{pick, 3'b000} +: 8];
  assign pick_cfg  = baud_cfg[{pick, 1'b0} +: 2];
  assign tick_end  = baud_tick && (tcnt == TICK_LAST);
  assign bidx_inc  = 3'(bidx + 3'd1);

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    tcnt_n     = tcnt;
    bidx_n     = bidx;
    scnt_n     = scnt;
    rr_n       = rr;
    owner_n    = owner;
    baud_sel_n = baud_sel;
    grant_n    = 4'b0000;
    tx_n       = tx;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (found) begin
          shreg_n       = pick_data;
          owner_n       = pick;
          grant_n[pick] = 1'b1;
          busy_n        = 1'b1;
          rr_n          = pick + 2'd1;
          tcnt_n        = 4'd0;
          bidx_n        = 3'd0;
          scnt_n        = 8'd0;
          if (pick_cfg == baud_sel) begin
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            baud_sel_n = pick_cfg;
            state_n    = S_SETTLE;
          end
        end
      end
      // Counts raw clocks so the generator has switched before any tick is trusted.
      S_SETTLE: begin
        if (scnt == SETTLE_LAST) begin
          state_n = S_START;
          tx_n    = 1'b0;
          tcnt_n  = 4'd0;
          bidx_n  = 3'd0;
        end else begin
          scnt_n = scnt + 8'd1;
        end
      end
      S_START: begin
        if (tick_end) begin
          state_n = S_DATA;
          tcnt_n  = 4'd0;
          bidx_n  = 3'd0;
          tx_n    = shreg[0];
        end else if (baud_tick) begin
          tcnt_n = tcnt + 4'd1;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          tcnt_n = 4'd0;
          if (bidx == 3'd7) begin
            state_n = S_STOP;
            bidx_n  = 3'd0;
            tx_n    = 1'b1;
          end else begin
            bidx_n = bidx_inc;
            tx_n   = shreg[bidx_inc];
          end
        end else if (baud_tick) begin
          tcnt_n = tcnt + 4'd1;
        end
      end
      S_STOP: begin
        if (tick_end) begin
          state_n = S_IDLE;
          tcnt_n  = 4'd0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          tx_n    = 1'b1;
        end else if (baud_tick) begin
          tcnt_n = tcnt + 4'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= 8'd0;
      tcnt     <= 4'd0;
      bidx     <= 3'd0;
      scnt     <= 8'd0;
      rr       <= 2'd0;
      owner    <= 2'd0;
      baud_sel <= 2'b00;
      grant    <= 4'b0000;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      tcnt     <= tcnt_n;
      bidx     <= bidx_n;
      scnt     <= scnt_n;
      rr       <= rr_n;
      owner    <= owner_n;
      baud_sel <= baud_sel_n;
      grant    <= grant_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched
module tb_uart_tx_sched;
  localparam int OVS    = 16;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] data_in = 32'b0;
  logic [7:0]  baud_cfg = 8'b0;
  logic        baud_tick = 1'b0;
  logic [1:0]  baud_sel;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        tx, busy, done;

  uart_tx_sched #(.OVS(OVS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .baud_cfg(baud_cfg),
    .baud_tick(baud_tick), .baud_sel(baud_sel), .grant(grant), .owner(owner),
    .tx(tx), .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] sel;
    int         lat;
    logic [7:0] b;
    bit         gap;
    bit         abort;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_done_cyc = -100;
  int   tick_phase = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end
  initial forever begin
    @(posedge clk);
    #1;
    baud_tick  = (tick_phase == 2);
    tick_phase = (tick_phase + 1) % 3;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] sel, input int lat,
                              input logic [7:0] b, input bit gap, input bit abort);
    exp_t e;
    e.g = g; e.sel = sel; e.lat = lat; e.b = b; e.gap = gap; e.abort = abort;
    return e;
  endfunction

  // Monitor: pops one expectation per grant and follows that frame on the line.
  initial begin : monitor
    exp_t e;
    int lat, n, guard, glitch;
    bit aborted;
    logic [9:0] cap, want;
    wait (rst == 1'b0);
    forever begin
      @(negedge clk);
      if (!rst && grant !== 4'b0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_grant", grant, 4'b0);
        end else begin
          e = sbq.pop_front();
          chk("grant", grant, e.g);
          chk("owner", owner, enc(e.g));
          chk("baud_sel", baud_sel, e.sel);
          chk("busy_at_grant", busy, 1);
          if (e.gap) chk("done_to_grant_gap", cyc - last_done_cyc, 1);
          lat = 0;
          while (tx !== 1'b0 && lat < 40 && !rst) begin @(negedge clk); lat++; end
          chk("start_latency", lat, e.lat);
          want = {1'b1, e.b, 1'b0};
          cap = '1; n = 0; guard = 0; glitch = 0; aborted = 0;
          while (n < 10 * OVS && guard < 20000) begin
            if (rst) begin aborted = 1; break; end
            if (baud_tick) begin
              if (n % OVS == 0) cap[n / OVS] = tx;
              else if (tx !== cap[n / OVS]) glitch++;
              n++;
            end
            if (n < 10 * OVS) begin @(negedge clk); guard++; end
          end
          chk("frame_aborted", aborted, e.abort);
          if (!aborted) begin
            chk("frame_bits", cap, want);
            chk("bit_hold_glitches", glitch, 0);
            @(negedge clk);
            chk("done_pulse", done, 1);
            chk("busy_after_stop", busy, 0);
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic wait_grants(input int cnt);
    int seen = 0;
    int g = 0;
    while (seen < cnt && g < 20000) begin
      @(negedge clk); g++;
      if (grant !== 4'b0) seen++;
    end
    if (seen < cnt) chk("wait_grant_timeout", seen, cnt);
  endtask

  task automatic wait_done();
    int g = 0;
    bit hit = 0;
    while (!hit && g < 20000) begin
      @(negedge clk); g++;
      if (done === 1'b1) hit = 1;
    end
    if (!hit) chk("wait_done_timeout", 0, 1);
  endtask

  initial begin : stim
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_owner", owner, 0);
    chk("rst_baud_sel", baud_sel, 0);
    rst = 1'b0;

    // Four requesters held: rotation 0,1,2,3,0 with no settle.
    @(posedge clk); #1;
    data_in = 32'hF0_5A_80_A5;
    baud_cfg = 8'h00;
    sbq.push_back(mk(4'b0001, 2'b00, 0, 8'hA5, 0, 0));
    sbq.push_back(mk(4'b0010, 2'b00, 0, 8'h80, 1, 0));
    sbq.push_back(mk(4'b0100, 2'b00, 0, 8'h5A, 1, 0));
    sbq.push_back(mk(4'b1000, 2'b00, 0, 8'hF0, 1, 0));
    sbq.push_back(mk(4'b0001, 2'b00, 0, 8'hA5, 1, 0));
    req = 4'b1111;
    wait_grants(5);
    @(posedge clk); #1; req = 4'b0;
    wait_done();
    repeat (3) @(posedge clk);

    // New baud select forces settle; second back-to-back frame skips it, data change mid-frame ignored.
    #1;
    data_in[15:8] = 8'h3C;
    baud_cfg[3:2] = 2'b01;
    sbq.push_back(mk(4'b0010, 2'b01, SETTLE, 8'h3C, 0, 0));
    sbq.push_back(mk(4'b0010, 2'b01, 0, 8'h81, 1, 0));
    req = 4'b0010;
    wait_grants(1);
    @(posedge clk); #1; data_in[15:8] = 8'h81;
    wait_grants(1);
    @(posedge clk); #1; req = 4'b0;
    wait_done();
    repeat (3) @(posedge clk);

    // Requester 2 raised mid-frame waits for IDLE.
    #1;
    data_in[7:0] = 8'h96; data_in[23:16] = 8'h3F;
    baud_cfg[1:0] = 2'b01; baud_cfg[5:4] = 2'b01;
    sbq.push_back(mk(4'b0001, 2'b01, 0, 8'h96, 0, 0));
    sbq.push_back(mk(4'b0100, 2'b01, 0, 8'h3F, 1, 0));
    req = 4'b0001;
    wait_grants(1);
    @(posedge clk); #1; req = 4'b0100;
    wait_grants(1);
    @(posedge clk); #1; req = 4'b0;
    wait_done();
    repeat (3) @(posedge clk);

    // Reset in the middle of data bit 3.
    #1;
    data_in[31:24] = 8'h55; baud_cfg[7:6] = 2'b01;
    sbq.push_back(mk(4'b1000, 2'b01, 0, 8'h55, 0, 1));
    req = 4'b1000;
    wait_grants(1);
    @(posedge clk); #1; req = 4'b0;
    n = 0;
    while (n < 70) begin @(negedge clk); if (baud_tick) n++; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    sbq.push_back(mk(4'b0001, 2'b00, 0, 8'h0F, 0, 0));
    baud_cfg = 8'h00;
    data_in[7:0] = 8'h0F;
    req = 4'b1001;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_owner_mid", owner, 0);
    chk("rst_baud_sel_mid", baud_sel, 0);
    rst = 1'b0;
    wait_grants(1);
    @(posedge clk); #1; req = 4'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
